prim_lfsr_ms: RTL and testbench

//   Parametrised multi-step Galois LFSR pseudo-random source with a valid/ready output stream.

---
 rtl/prim_lfsr_ms.sv | 127 ++++++++++++
 tb/tb_prim_lfsr_ms.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/prim_lfsr_ms.sv
// prim_lfsr_ms: multi-step Galois LFSR random source with a valid/ready output
// stream, runtime seed load and an optional periodic reseed request.
//   clk_i, rst_ni                 clock, async active-low reset
//   seed_valid_i, seed_i          load a new LFSR state (seed_ready_o always 1)
//   out_valid_o, out_ready_i      output handshake, data_o = low OutDw state bits
//   reseed_req_o                  high while waiting for a fresh seed
//   lockup_o                      1-cycle pulse when a zero state was replaced
module prim_lfsr_ms #(
   parameter int unsigned LfsrDw         = 32,
   parameter int unsigned OutDw          = 8,
   parameter int unsigned StepsPerCycle  = 1,
   parameter logic [63:0] Coeffs         = 64'h80000057,
   parameter logic [63:0] Seed           = 64'd1,
   parameter int unsigned ReseedInterval = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              seed_valid_i,
   input  logic [LfsrDw-1:0] seed_i,
   output logic              seed_ready_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [OutDw-1:0]  data_o,
   output logic              reseed_req_o,
   output logic              lockup_o
);

   localparam logic [LfsrDw-1:0] CoeffsW   = Coeffs[LfsrDw-1:0];
   localparam logic [LfsrDw-1:0] SeedW     = Seed[LfsrDw-1:0];
   localparam logic [31:0]       IntervalW = 32'(ReseedInterval);

   typedef enum logic {
      ST_RUN,
      ST_RESEED
   } state_e;

   state_e             state_q, state_d;
   logic [LfsrDw-1:0]  lfsr_q, lfsr_d;
   logic [LfsrDw-1:0]  step;
   logic [31:0]        cnt_q, cnt_d;
   logic               lockup_q, lockup_d;
   logic               fire;

   assign seed_ready_o = 1'b1;
   assign out_valid_o  = (state_q == ST_RUN);
   assign reseed_req_o = (state_q == ST_RESEED);
   assign fire         = out_valid_o & out_ready_i;
   assign data_o       = lfsr_q[OutDw-1:0];
   assign lockup_o     = lockup_q;

   // Unrolled chain of Galois steps.
   always_comb begin
      step = lfsr_q;
      for (int unsigned i = 0; i < StepsPerCycle; i++) begin
         step = (step >> 1) ^ ({LfsrDw{step[0]}} & CoeffsW);
      end
   end

   // Seed load wins over the advance; an all-zero result would lock the
   // LFSR, so it is swapped for the fallback seed and flagged.
   always_comb begin
      lfsr_d   = lfsr_q;
      lockup_d = 1'b0;
      if (seed_valid_i) begin
         lfsr_d = seed_i;
      end else if (fire) begin
         lfsr_d = step;
      end
      if ((seed_valid_i || fire) && (lfsr_d == '0)) begin
         lfsr_d   = SeedW;
         lockup_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (seed_valid_i) begin
               cnt_d = '0;
            end else if (fire) begin
               if ((IntervalW != '0) && (cnt_q + 32'd1 == IntervalW)) begin
                  cnt_d   = '0;
                  state_d = ST_RESEED;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end
         ST_RESEED: begin
            if (seed_valid_i) begin
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_RUN;
         lfsr_q   <= SeedW;
         cnt_q    <= '0;
         lockup_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         cnt_q    <= cnt_d;
         lockup_q <= lockup_d;
      end
   end

   a_coeffs_nz : assert property (@(posedge clk_i) CoeffsW != '0);
   a_seed_nz   : assert property (@(posedge clk_i) SeedW != '0);
   a_out_width : assert property (@(posedge clk_i) OutDw <= LfsrDw);

   a_data_stable : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (out_valid_o && !out_ready_i && !seed_valid_i) |=> $stable(data_o)
   );

endmodule

// File: tb/tb_prim_lfsr_ms.sv
// tb_prim_lfsr_ms: directed checks of prim_lfsr_ms with an 8-bit LFSR,
// taps B8, seed 01, in three configurations (1 step, 2 steps, reseed every 3).
module tb_prim_lfsr_ms;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       sv1 = 1'b0, sv2 = 1'b0, sv3 = 1'b0;
   logic [7:0] sd1 = '0, sd2 = '0, sd3 = '0;
   logic       rdy1 = 1'b0, rdy2 = 1'b0, rdy3 = 1'b0;
   logic       sr1, sr2, sr3;
   logic       v1, v2, v3;
   logic [7:0] d1, d2, d3;
   logic       rq1, rq2, rq3;
   logic       lk1, lk2, lk3;

   int total = 0;
   int bad   = 0;
   int k     = 0;
   int dups  = 0;
   bit track = 1'b0;
   bit seen [256];

   always #5 clk = ~clk;

   prim_lfsr_ms #(
      .LfsrDw(8), .OutDw(8), .StepsPerCycle(1),
      .Coeffs(64'hB8), .Seed(64'h01), .ReseedInterval(0)
   ) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .seed_valid_i(sv1), .seed_i(sd1), .seed_ready_o(sr1),
      .out_valid_o(v1), .out_ready_i(rdy1), .data_o(d1),
      .reseed_req_o(rq1), .lockup_o(lk1)
   );

   prim_lfsr_ms #(
      .LfsrDw(8), .OutDw(8), .StepsPerCycle(2),
      .Coeffs(64'hB8), .Seed(64'h01), .ReseedInterval(0)
   ) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n),
      .seed_valid_i(sv2), .seed_i(sd2), .seed_ready_o(sr2),
      .out_valid_o(v2), .out_ready_i(rdy2), .data_o(d2),
      .reseed_req_o(rq2), .lockup_o(lk2)
   );

   prim_lfsr_ms #(
      .LfsrDw(8), .OutDw(8), .StepsPerCycle(1),
      .Coeffs(64'hB8), .Seed(64'h01), .ReseedInterval(3)
   ) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n),
      .seed_valid_i(sv3), .seed_i(sd3), .seed_ready_o(sr3),
      .out_valid_o(v3), .out_ready_i(rdy3), .data_o(d3),
      .reseed_req_o(rq3), .lockup_o(lk3)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      k++;
      if (track && d1 != 8'h01) begin
         if (seen[d1]) dups++;
         seen[d1] = 1'b1;
      end
   endtask

   initial begin
      // In reset
      @(negedge clk);
      chk("rst_data", 32'(d1), 32'h01);
      chk("rst_valid", 32'(v1), 32'h1);
      chk("rst_req", 32'(rq3), 32'h0);
      chk("rst_lockup", 32'(lk1), 32'h0);
      chk("seed_ready", 32'(sr1 & sr2 & sr3), 32'h1);
      rst_n = 1'b1;

      // Backpressure: 5 cycles with ready low
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold1", 32'(d1), 32'h01);
      end
      chk("bp_hold2", 32'(d2), 32'h01);
      chk("bp_hold3", 32'(d3), 32'h01);

      rdy1 = 1'b1; rdy2 = 1'b1; rdy3 = 1'b1;
      k = 0; track = 1'b1; seen[1] = 1'b1;

      tick(); // k=1
      chk("seq1_k1", 32'(d1), 32'hB8);
      chk("seq2_k1", 32'(d2), 32'h5C);
      chk("rs_k1", 32'(d3), 32'hB8);
      tick(); // k=2
      chk("seq1_k2", 32'(d1), 32'h5C);
      chk("seq2_k2", 32'(d2), 32'h17);
      chk("rs_k2_valid", 32'(v3), 32'h1);
      tick(); // k=3: third fire done
      chk("seq1_k3", 32'(d1), 32'h2E);
      chk("rs_k3_valid", 32'(v3), 32'h0);
      chk("rs_k3_req", 32'(rq3), 32'h1);
      chk("rs_k3_data", 32'(d3), 32'h2E);
      sv3 = 1'b1; sd3 = 8'h5A;
      tick(); // k=4
      chk("seq1_k4", 32'(d1), 32'h17);
      chk("rs_k4_valid", 32'(v3), 32'h1);
      chk("rs_k4_req", 32'(rq3), 32'h0);
      chk("rs_k4_data", 32'(d3), 32'h5A);
      sv3 = 1'b0;
      tick(); // k=5
      chk("seq1_k5", 32'(d1), 32'hB3);
      chk("rs_k5_data", 32'(d3), 32'h2D);
      tick(); // k=6
      chk("rs_k6_data", 32'(d3), 32'hAE);
      chk("rs_k6_valid", 32'(v3), 32'h1);
      tick(); // k=7: third fire after reload
      chk("rs_k7_req", 32'(rq3), 32'h1);
      chk("rs_k7_data", 32'(d3), 32'h57);
      sv3 = 1'b1; sd3 = 8'h33;
      tick(); // k=8
      chk("rs_k8_data", 32'(d3), 32'h33);
      chk("rs_k8_valid", 32'(v3), 32'h1);
      // Zero seed together with a fire
      sd3 = 8'h00;
      tick(); // k=9
      chk("zero_data", 32'(d3), 32'h01);
      chk("zero_lockup", 32'(lk3), 32'h1);
      sv3 = 1'b0;
      tick(); // k=10
      chk("zero_lockup_end", 32'(lk3), 32'h0);
      chk("zero_next", 32'(d3), 32'hB8);
      tick(); // k=11
      chk("zero_cnt_v", 32'(v3), 32'h1);
      chk("zero_cnt_d", 32'(d3), 32'h5C);
      tick(); // k=12
      chk("zero_cnt_req", 32'(rq3), 32'h1);

      // Period of the 1-step LFSR
      while (d1 != 8'h01 && k < 400) tick();
      chk("period", 32'(k), 32'd255);
      chk("no_repeat", 32'(dups), 32'd0);
      chk("rs_still_req", 32'(rq3), 32'h1);

      // Reset while waiting for a reseed
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_req", 32'(rq3), 32'h0);
      chk("rst_mid_valid", 32'(v3), 32'h1);
      chk("rst_mid_data", 32'(d3), 32'h01);
      rdy3 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_after_req", 32'(rq3), 32'h0);
      chk("rst_after_valid", 32'(v3), 32'h1);
      chk("rst_after_data", 32'(d3), 32'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
